// File: rtl/pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared types and constants for the fetch-stage PC controller.
//   PC_W             : width of all program-counter values
//   DEFAULT_RESET_PC : default reset vector
//   fetch_state_t    : fetch controller state (boot / run / error)
//   ras_ptr_w()      : width of a return-stack pointer that can hold 0..depth
// ---------------------------------------------------------------------------
package pc_ctrl_pkg;

    localparam int PC_W = 16;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_t;

    // One extra bit so that a completely full stack (sp == depth) is representable.
    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
// Hardware return-address stack with optional circular overwrite on overflow.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset (clears pointer and entries)
//   push      in   push din (call)
//   pop       in   pop top (ret); push+pop together replaces the top entry,
//                  or acts as a plain push when the stack is empty
//   din       in   value to push / replace with
//   top       out  top entry, 0 when empty (combinational)
//   empty     out  pointer == 0
//   full      out  pointer == DEPTH
//   ovf_pulse out  this cycle's push hits a full stack
//   unf_pulse out  this cycle's pop hits an empty stack
// With WRAP != 0 an overflowing push overwrites the oldest entry; with
// WRAP == 0 the overflowing push is dropped and only ovf_pulse reports it.
// ---------------------------------------------------------------------------
module ras_stack
    import pc_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WRAP  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            ovf_pulse,
    output logic            unf_pulse
);

    localparam int PW = ras_ptr_w(DEPTH);
    localparam int IW = $clog2(DEPTH);

    // r_sp counts live entries; r_base is the physical slot of the oldest
    // entry, which only moves when a wrapping push discards the oldest value.
    logic [PW-1:0]   r_sp;
    logic [IW-1:0]   r_base;
    logic [PC_W-1:0] r_mem [DEPTH];

    logic            w_empty;
    logic            w_full;
    logic [IW-1:0]   w_push_idx;
    logic [IW-1:0]   w_top_idx;
    logic            w_replace;
    logic            w_push_only;
    logic            w_pop_only;
    logic            w_we;
    logic [IW-1:0]   w_waddr;

    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == PW'(DEPTH));

    // When full, the low index bits of r_sp are zero, so w_push_idx equals
    // r_base: a wrapping push lands exactly on the oldest entry.
    assign w_push_idx = r_base + r_sp[IW-1:0];
    assign w_top_idx  = r_base + r_sp[IW-1:0] - IW'(1);

    assign w_replace   = push && pop && !w_empty;
    assign w_push_only = push && (!pop || w_empty);
    assign w_pop_only  = pop && !push;

    assign ovf_pulse = w_push_only && w_full;
    assign unf_pulse = w_pop_only && w_empty;

    assign w_we    = w_replace || (w_push_only && (!w_full || (WRAP != 0)));
    assign w_waddr = w_replace ? w_top_idx : w_push_idx;

    assign top   = w_empty ? '0 : r_mem[w_top_idx];
    assign empty = w_empty;
    assign full  = w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp   <= '0;
            r_base <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we) begin
                r_mem[w_waddr] <= din;
            end
            if (w_push_only) begin
                if (!w_full) begin
                    r_sp <= r_sp + PW'(1);
                end else if (WRAP != 0) begin
                    r_base <= r_base + IW'(1);
                end
            end else if (w_pop_only && !w_empty) begin
                r_sp <= r_sp - PW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// Fetch-stage controller: owns the PC register, sequences it from redirects,
// stalls and increments, and keeps the return-address stack.
// Ports:
//   clk, rst       clock / asynchronous active-high reset
//   stall          hold PC (ignored when do_jump is set)
//   do_jump        redirect taken this cycle; also qualifies call/ret
//   pc_next        redirect target
//   call, ret      resolved call / ret in EX
//   ex_pc_plus1    return address to push on a call
//   pc, pc_plus1   current fetch address and its successor
//   addr_ret       top of return stack (0 when empty)
//   fetch_valid    word fetched at pc is to be issued (RUN only)
//   flush          combinational, do_jump while running
//   ras_empty/full return-stack occupancy
//   ras_ovf        sticky, wrapping overflow seen
//   err            sticky, controller is in the error state
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          RAS_DEPTH   = 8,
    parameter int          RAS_WRAP    = 0,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        do_jump,
    input  logic [15:0] pc_next,
    input  logic        call,
    input  logic        ret,
    input  logic [15:0] ex_pc_plus1,
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    output logic [15:0] addr_ret,
    output logic        fetch_valid,
    output logic        flush,
    output logic        ras_empty,
    output logic        ras_full,
    output logic        ras_ovf,
    output logic        err
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_t    r_state;
    logic [3:0]      r_boot_cnt;
    logic [PC_W-1:0] r_pc;
    logic            r_fetch_valid;
    logic            r_err;
    logic            r_ras_ovf;

    logic            w_run;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf;
    logic            w_unf;
    logic [PC_W-1:0] w_top;
    logic            w_empty;
    logic            w_full;

    assign w_run = (r_state == ST_RUN);

    // Stack traffic is qualified by the redirect itself and frozen outside RUN.
    assign w_push = w_run && do_jump && call;
    assign w_pop  = w_run && do_jump && ret;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WRAP  (RAS_WRAP)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .din       (ex_pc_plus1),
        .top       (w_top),
        .empty     (w_empty),
        .full      (w_full),
        .ovf_pulse (w_ovf),
        .unf_pulse (w_unf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_boot_cnt    <= '0;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_err         <= 1'b0;
            r_ras_ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (r_boot_cnt == BOOT_LAST) begin
                        r_state       <= ST_RUN;
                        r_fetch_valid <= 1'b1;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    // Redirect beats stall; the PC still moves on the edge
                    // that detects a stack fault.
                    if (do_jump) begin
                        r_pc <= pc_next;
                    end else if (!stall) begin
                        r_pc <= r_pc + 16'd1;
                    end
                    if (w_unf || (w_ovf && (RAS_WRAP == 0))) begin
                        r_state       <= ST_ERR;
                        r_fetch_valid <= 1'b0;
                        r_err         <= 1'b1;
                    end
                    if (w_ovf && (RAS_WRAP != 0)) begin
                        r_ras_ovf <= 1'b1;
                    end
                end
                ST_ERR: begin
                    r_fetch_valid <= 1'b0;
                    r_err         <= 1'b1;
                end
                default: begin
                    r_state       <= ST_ERR;
                    r_fetch_valid <= 1'b0;
                    r_err         <= 1'b1;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign pc_plus1    = r_pc + 16'd1;
    assign addr_ret    = w_top;
    assign fetch_valid = r_fetch_valid;
    assign flush       = w_run && do_jump;
    assign ras_empty   = w_empty;
    assign ras_full    = w_full;
    assign ras_ovf     = r_ras_ovf;
    assign err         = r_err;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Two instances: u_a wraps on RAS overflow and is tracked by a queue-based
// reference model every cycle; u_b errors on overflow and gets directed checks.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    localparam logic [15:0] RPC   = 16'h0010;
    localparam int          DEPTH = 4;
    localparam int          BOOTC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        stall = 1'b0, do_jump = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] pc_next = '0, ex_pc_plus1 = '0;

    logic [15:0] a_pc, a_pc_plus1, a_addr_ret, b_pc, b_pc_plus1, b_addr_ret;
    logic        a_fv, a_flush, a_empty, a_full, a_ovf, a_err;
    logic        b_fv, b_flush, b_empty, b_full, b_ovf, b_err;

    pc_fetch_ctrl #(.RESET_PC(RPC), .RAS_DEPTH(DEPTH), .RAS_WRAP(1), .BOOT_CYCLES(BOOTC)) u_a (
        .clk(clk), .rst(rst_a), .stall(stall), .do_jump(do_jump), .pc_next(pc_next),
        .call(call), .ret(ret), .ex_pc_plus1(ex_pc_plus1),
        .pc(a_pc), .pc_plus1(a_pc_plus1), .addr_ret(a_addr_ret), .fetch_valid(a_fv),
        .flush(a_flush), .ras_empty(a_empty), .ras_full(a_full), .ras_ovf(a_ovf), .err(a_err));

    pc_fetch_ctrl #(.RESET_PC(RPC), .RAS_DEPTH(DEPTH), .RAS_WRAP(0), .BOOT_CYCLES(BOOTC)) u_b (
        .clk(clk), .rst(rst_b), .stall(stall), .do_jump(do_jump), .pc_next(pc_next),
        .call(call), .ret(ret), .ex_pc_plus1(ex_pc_plus1),
        .pc(b_pc), .pc_plus1(b_pc_plus1), .addr_ret(b_addr_ret), .fetch_valid(b_fv),
        .flush(b_flush), .ras_empty(b_empty), .ras_full(b_full), .ras_ovf(b_ovf), .err(b_err));

    int n_total = 0;
    int n_bad   = 0;
    bit chk_a   = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model for u_a (wrapping stack) ----------------
    int          m_mode;        // 0 boot, 1 run, 2 error
    int          m_boot_edges;
    logic [15:0] m_pc;
    logic [15:0] m_q[$];        // back = top of stack
    bit          m_ovf;

    task automatic model_reset();
        m_mode = 0; m_boot_edges = 0; m_pc = RPC; m_q.delete(); m_ovf = 0;
    endtask

    task automatic model_step();
        if (m_mode == 0) begin
            m_boot_edges++;
            if (m_boot_edges == BOOTC) m_mode = 1;
        end else if (m_mode == 1) begin
            if (do_jump) begin
                if (call && ret) begin
                    if (m_q.size() == 0) m_q.push_back(ex_pc_plus1);
                    else m_q[m_q.size()-1] = ex_pc_plus1;
                end else if (call) begin
                    if (m_q.size() == DEPTH) begin
                        void'(m_q.pop_front());
                        m_ovf = 1;
                    end
                    m_q.push_back(ex_pc_plus1);
                end else if (ret) begin
                    if (m_q.size() == 0) m_mode = 2;
                    else void'(m_q.pop_back());
                end
            end
            if (do_jump) m_pc = pc_next;
            else if (!stall) m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic model_check();
        logic [15:0] p1;
        logic [15:0] ar;
        p1 = m_pc + 16'd1;
        ar = (m_q.size() == 0) ? 16'h0000 : m_q[m_q.size()-1];
        chk("m_pc", a_pc, m_pc);
        chk("m_pc_plus1", a_pc_plus1, p1);
        chk("m_addr_ret", a_addr_ret, ar);
        chk("m_fetch_valid", a_fv, m_mode == 1);
        chk("m_flush", a_flush, (m_mode == 1) && do_jump);
        chk("m_ras_empty", a_empty, m_q.size() == 0);
        chk("m_ras_full", a_full, m_q.size() == DEPTH);
        chk("m_ras_ovf", a_ovf, m_ovf);
        chk("m_err", a_err, m_mode == 2);
    endtask

    // Called just after a falling edge: set inputs, settle, check pre-edge outputs.
    task automatic drive(input logic s, input logic j, input logic c, input logic r,
                         input logic [15:0] pn, input logic [15:0] ex);
        stall = s; do_jump = j; call = c; ret = r; pc_next = pn; ex_pc_plus1 = ex;
        #1;
        if (chk_a) model_check();
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (chk_a) model_step();
        @(negedge clk);
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        #1;
        model_reset();
        model_check();
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    // ---------------- directed table for u_a ----------------
    typedef struct {
        logic        s, j, c, r;
        logic [15:0] pn, ex;
        logic [15:0] e_pc, e_ar;
        logic        e_fl, e_fv, e_em;
    } vec_t;

    vec_t tbl[26];

    task automatic row(input int i, input logic s, input logic j, input logic c, input logic r,
                       input logic [15:0] pn, input logic [15:0] ex,
                       input logic [15:0] epc, input logic [15:0] ear,
                       input logic efl, input logic efv, input logic eem);
        tbl[i].s = s; tbl[i].j = j; tbl[i].c = c; tbl[i].r = r;
        tbl[i].pn = pn; tbl[i].ex = ex; tbl[i].e_pc = epc; tbl[i].e_ar = ear;
        tbl[i].e_fl = efl; tbl[i].e_fv = efv; tbl[i].e_em = eem;
    endtask

    logic [15:0] wrap_vals[5];

    initial begin
        // Each row: inputs for this cycle, outputs expected before its edge.
        // Boot: two cycles without fetch, then the reset vector is fetched.
        row( 0, 0,0,0,0, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 0, 0, 1);
        row( 1, 0,0,0,0, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 0, 0, 1);
        row( 2, 0,0,0,0, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 0, 1, 1);
        row( 3, 0,0,0,0, 16'h0000, 16'h0000, 16'h0011, 16'h0000, 0, 1, 1);
        row( 4, 0,1,0,0, 16'h0020, 16'h0000, 16'h0012, 16'h0000, 1, 1, 1);
        // Stall three cycles, then redirect with stall still high.
        row( 5, 1,0,0,0, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 0, 1, 1);
        row( 6, 1,0,0,0, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 0, 1, 1);
        row( 7, 1,0,0,0, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 0, 1, 1);
        row( 8, 1,1,0,0, 16'h0100, 16'h0000, 16'h0020, 16'h0000, 1, 1, 1);
        row( 9, 0,0,0,0, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 0, 1, 1);
        // Nested calls and returns.
        row(10, 0,1,1,0, 16'h0200, 16'h0031, 16'h0101, 16'h0000, 1, 1, 1);
        row(11, 0,1,1,0, 16'h0300, 16'h0051, 16'h0200, 16'h0031, 1, 1, 0);
        row(12, 0,1,0,1, 16'h0051, 16'h0000, 16'h0300, 16'h0051, 1, 1, 0);
        row(13, 0,1,0,1, 16'h0031, 16'h0000, 16'h0051, 16'h0031, 1, 1, 0);
        row(14, 0,0,0,0, 16'h0000, 16'h0000, 16'h0031, 16'h0000, 0, 1, 1);
        // PC wrap at 0xFFFF.
        row(15, 0,1,0,0, 16'hFFFF, 16'h0000, 16'h0032, 16'h0000, 1, 1, 1);
        row(16, 0,0,0,0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 0, 1, 1);
        row(17, 0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1);
        // Two calls, then call+ret together replaces the top at depth 2.
        row(18, 0,1,1,0, 16'h0040, 16'h00A1, 16'h0001, 16'h0000, 1, 1, 1);
        row(19, 0,1,1,0, 16'h0050, 16'h00A2, 16'h0040, 16'h00A1, 1, 1, 0);
        row(20, 0,1,1,1, 16'h0060, 16'h00B2, 16'h0050, 16'h00A2, 1, 1, 0);
        row(21, 0,0,0,0, 16'h0000, 16'h0000, 16'h0060, 16'h00B2, 0, 1, 0);
        row(22, 0,1,0,1, 16'h0070, 16'h0000, 16'h0061, 16'h00B2, 1, 1, 0);
        row(23, 0,0,0,0, 16'h0000, 16'h0000, 16'h0070, 16'h00A1, 0, 1, 0);
        row(24, 0,1,0,1, 16'h0080, 16'h0000, 16'h0071, 16'h00A1, 1, 1, 0);
        row(25, 0,0,0,0, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 0, 1, 1);

        wrap_vals[0] = 16'h0A0A; wrap_vals[1] = 16'h0B0B; wrap_vals[2] = 16'h0C0C;
        wrap_vals[3] = 16'h0D0D; wrap_vals[4] = 16'h0E0E;

        @(negedge clk);
        reset_a();
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].s, tbl[i].j, tbl[i].c, tbl[i].r, tbl[i].pn, tbl[i].ex);
            chk($sformatf("t%0d_pc", i), a_pc, tbl[i].e_pc);
            chk($sformatf("t%0d_addr_ret", i), a_addr_ret, tbl[i].e_ar);
            chk($sformatf("t%0d_flush", i), a_flush, tbl[i].e_fl);
            chk($sformatf("t%0d_fetch_valid", i), a_fv, tbl[i].e_fv);
            chk($sformatf("t%0d_ras_empty", i), a_empty, tbl[i].e_em);
            $display("vec %0d pc=%04h addr_ret=%04h flush=%0b fv=%0b", i, a_pc, a_addr_ret, a_flush, a_fv);
            clock_edge();
        end

        // Wrapping overflow: five calls into a 4-deep stack drop the oldest.
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 0, 16'h0200 + 16'(i), wrap_vals[i]);
            clock_edge();
        end
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        chk("wrap_ovf", a_ovf, 1);
        chk("wrap_full", a_full, 1);
        chk("wrap_top", a_addr_ret, 16'h0E0E);
        clock_edge();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 1, 16'h0300 + 16'(k), 16'h0000);
            chk($sformatf("wrap_ret%0d", k), a_addr_ret, wrap_vals[4-k]);
            $display("wrap ret %0d addr_ret=%04h", k, a_addr_ret);
            clock_edge();
        end
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        chk("wrap_empty", a_empty, 1);
        clock_edge();
        // Underflow: PC still takes the redirect, then everything freezes.
        drive(0, 1, 0, 1, 16'h0999, 16'h0000);
        clock_edge();
        drive(0, 1, 0, 0, 16'h0555, 16'h0000);
        chk("unf_err", a_err, 1);
        chk("unf_fv", a_fv, 0);
        chk("unf_flush", a_flush, 0);
        chk("unf_pc", a_pc, 16'h0999);
        clock_edge();
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        chk("err_pc_frozen", a_pc, 16'h0999);
        clock_edge();

        // Randomized traffic against the model, with occasional async resets.
        reset_a();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_a();
                $display("rand %0d reset", n);
            end else begin
                drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                      16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
                $display("rand %0d pc=%04h sp_top=%04h err=%0b", n, a_pc, a_addr_ret, a_err);
                clock_edge();
            end
        end

        // Non-wrapping instance: overflow enters ERR, reset recovers.
        chk_a = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 16'h0000, 16'h0000);
            clock_edge();
        end
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        chk("b_run_fv", b_fv, 1);
        clock_edge();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0, 16'h0400 + 16'(i), 16'h1001 + 16'(i));
            clock_edge();
        end
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        chk("b_full", b_full, 1);
        chk("b_top", b_addr_ret, 16'h1004);
        chk("b_err_pre", b_err, 0);
        clock_edge();
        drive(0, 1, 1, 0, 16'h0500, 16'h1005);
        clock_edge();
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        chk("b_ovf_err", b_err, 1);
        chk("b_ovf_fv", b_fv, 0);
        chk("b_ovf_top", b_addr_ret, 16'h1004);
        chk("b_ovf_full", b_full, 1);
        chk("b_ovf_sticky", b_ovf, 0);
        chk("b_ovf_pc", b_pc, 16'h0500);
        clock_edge();
        drive(0, 1, 1, 0, 16'h0777, 16'h2222);
        chk("b_err_flush", b_flush, 0);
        clock_edge();
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        chk("b_err_pc", b_pc, 16'h0500);
        chk("b_err_top", b_addr_ret, 16'h1004);
        // Asynchronous reset in the middle of ERR.
        drive(0, 1, 0, 0, 16'h0888, 16'h0000);
        rst_b = 1'b1;
        #1;
        chk("b_rst_pc", b_pc, RPC);
        chk("b_rst_fv", b_fv, 0);
        chk("b_rst_flush", b_flush, 0);
        chk("b_rst_empty", b_empty, 1);
        chk("b_rst_full", b_full, 0);
        chk("b_rst_ovf", b_ovf, 0);
        chk("b_rst_err", b_err, 0);
        chk("b_rst_top", b_addr_ret, 16'h0000);
        $display("b reset pc=%04h err=%0b", b_pc, b_err);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 16'h0888, 16'h3333);
            chk($sformatf("b_boot%0d_fv", i), b_fv, 0);
            chk($sformatf("b_boot%0d_flush", i), b_flush, 0);
            chk($sformatf("b_boot%0d_pc", i), b_pc, RPC);
            clock_edge();
        end
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        chk("b_reboot_fv", b_fv, 1);
        chk("b_reboot_pc", b_pc, RPC);
        chk("b_reboot_empty", b_empty, 1);
        clock_edge();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch-stage controller that owns the architectural PC register and sequences it from the combinational next-PC datapath (branch/call/ret/increment). It holds a hardware return-address stack (RAS) that supplies the return target to the next-PC logic, handles pipeline stall and redirect priority, and gates instruction fetch through boot and error states. It sits between the hazard unit, the EX-stage branch resolution and instruction memory.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
RAS_DEPTH, 8, number of return-address stack entries (power of two, 2..16)
RAS_WRAP, 0, 1 = circular overwrite of oldest entry on overflow; 0 = overflow enters ERR
BOOT_CYCLES, 2, cycles after reset release with fetch suppressed (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  hazard unit: hold PC
do_jump  in  1  redirect taken this cycle (branch taken, call or ret), from next-PC logic
pc_next  in  16  redirect target from next-PC logic
call  in  1  resolved call in EX this cycle
ret  in  1  resolved ret in EX this cycle
ex_pc_plus1  in  16  PC+1 of the EX-stage instruction (return address to push)
pc  out  16  current fetch address
pc_plus1  out  16  pc + 1 (mod 2^16), to next-PC logic
addr_ret  out  16  RAS top entry; 16'h0000 when empty
fetch_valid  out  1  fetched word at pc is to be issued
flush  out  1  combinational, = do_jump in RUN; squashes IF/ID and ID/EX at this edge
ras_empty  out  1  stack pointer = 0
ras_full  out  1  stack pointer = RAS_DEPTH
ras_ovf  out  1  sticky: overflow occurred (RAS_WRAP=1 only)
err  out  1  sticky: in ERR state

Behaviour:
- Reset (async): pc=RESET_PC, state=BOOT, boot counter=0, sp=0, entries cleared, fetch_valid=0, flush=0, ras_empty=1, ras_full=0, ras_ovf=0, err=0, addr_ret=0. Reset mid-operation discards all stack contents and returns to BOOT.
- States: BOOT, RUN, ERR.
- BOOT: pc holds RESET_PC, fetch_valid=0, all inputs ignored, flush=0. After BOOT_CYCLES clocks -> RUN.
- RUN, priority per edge: do_jump > stall > increment.
  - do_jump=1: pc <= pc_next, even if stall=1 (redirect overrides stall).
  - stall=1 (no jump): pc holds.
  - otherwise: pc <= pc+1; 16'hFFFF wraps to 16'h0000.
  - fetch_valid=1 in RUN; flush=do_jump.
- RAS updates occur only in RUN, only when do_jump=1; call/ret without do_jump are ignored.
  - call only: entry[sp] <= ex_pc_plus1, sp+1.
  - ret only: sp-1.
  - call and ret together: top replaced with ex_pc_plus1, sp unchanged. If empty, this is treated as a push.
  - addr_ret = entry[sp-1] combinationally. Updated value visible the cycle after the push/pop.
- Overflow (call when full):
  - RAS_WRAP=1: oldest entry overwritten (circular), sp stays at RAS_DEPTH, ras_ovf<=1.
  - RAS_WRAP=0: -> ERR, no stack write.
- Underflow (ret when empty, no call): -> ERR. The pc update for that cycle still occurs.
- ERR: pc frozen, fetch_valid=0, flush=0, stack frozen, err=1 until reset.
- Latency: pc change visible 1 cycle after sampling edge; fetch_valid/err change on the same edge as state.

Decomposition:
- Package pc_ctrl_pkg: state enum {BOOT, RUN, ERR}, PC_W=16, default RESET_PC, RAS pointer width function (clog2(RAS_DEPTH)+1).
- Sub-module ras_stack: storage, pointer, push/pop/replace, full/empty, wrap mode. Ports: clk, rst, push, pop, din, top, empty, full, ovf_pulse, unf_pulse.
- Top holds PC register, boot counter, FSM.

Test Plan:
- Reset release, BOOT_CYCLES=2, RESET_PC=16'h0010 -> fetch_valid=0 for 2 cycles with pc=0x0010, then pc=0x0011, 0x0012 with fetch_valid=1.
- stall=1 for 3 cycles at pc=0x0020, then do_jump=1 with stall=1 and pc_next=0x0100 -> pc holds 0x0020 for 3 cycles, then 0x0100; flush=1 only in the jump cycle.
- Nested calls: call with ex_pc_plus1=0x0031, then 0x0051, then two rets -> addr_ret shows 0x0051 then 0x0031; ras_empty=1 after second pop.
- RAS_DEPTH=4, RAS_WRAP=1, 5 calls (returns A..E) -> ras_ovf=1, 4 rets give E,D,C,B; fifth ret -> err=1, fetch_valid=0, pc frozen.
- RAS_WRAP=0, 5th call on full stack -> ERR next cycle, stack unchanged; assert rst mid-ERR -> BOOT, all outputs at reset values.
- pc=0xFFFF, no stall/jump -> pc=0x0000; call+ret same cycle with sp=2 -> sp stays 2, top = new ex_pc_plus1.
